// File: rtl/speed_sequencer_pkg.sv
// Shared types and constants for the speed sequencer and its level counter.
// State encoding is fixed so it can be probed and displayed consistently.
package speed_sequencer_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_RUN    = 2'd1,
        ST_PAUSED = 2'd2,
        ST_OVER   = 2'd3
    } state_t;

    localparam int SPEED_W = 2;
    localparam logic [SPEED_W-1:0] SPEED_CEIL = 2'd3;

    // Out-of-range parameter values are pinned to the hardware ceiling.
    function automatic logic [SPEED_W-1:0] clamp_speed(input int value);
        if (value < 0) begin
            return '0;
        end else if (value > int'(SPEED_CEIL)) begin
            return SPEED_CEIL;
        end else begin
            return SPEED_W'(value);
        end
    endfunction

endpackage

// File: rtl/speed_sequencer_level_counter.sv
// Step counter and speed register: every STEPS_PER_LEVEL accepted steps the
// speed rises by one until it reaches i_max; o_level_up strobes on each raise.
module speed_sequencer_level_counter
    import speed_sequencer_pkg::*;
#(
    parameter int STEPS_PER_LEVEL = 16,
    parameter int START_SPEED     = 0
) (
    input  logic               i_clk,
    input  logic               i_rst_n,
    input  logic               i_inc,
    input  logic               i_load,
    input  logic [SPEED_W-1:0] i_max,
    output logic [SPEED_W-1:0] o_speed,
    output logic               o_level_up
);

    localparam logic [7:0]         LAST_STEP = 8'(STEPS_PER_LEVEL - 1);
    localparam logic [SPEED_W-1:0] START_VAL = clamp_speed(START_SPEED);

    logic [7:0]         r_step_count;
    logic [SPEED_W-1:0] r_speed;
    logic               r_level_up;
    logic               w_wrap;
    logic               w_can_raise;

    assign w_wrap      = (r_step_count == LAST_STEP);
    assign w_can_raise = (r_speed < i_max);

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_step_count <= 8'd0;
            r_speed      <= START_VAL;
            r_level_up   <= 1'b0;
        end else begin
            r_level_up <= 1'b0;
            if (i_load) begin
                r_step_count <= 8'd0;
                r_speed      <= START_VAL;
            end else if (i_inc) begin
                if (w_wrap) begin
                    r_step_count <= 8'd0;
                    // At the ceiling the level boundary passes silently.
                    if (w_can_raise) begin
                        r_speed    <= r_speed + 1'b1;
                        r_level_up <= 1'b1;
                    end
                end else begin
                    r_step_count <= r_step_count + 8'd1;
                end
            end
        end
    end

    assign o_speed    = r_speed;
    assign o_level_up = r_level_up;

endmodule

// File: rtl/speed_sequencer.sv
// Game speed sequencer: run/pause/over FSM gating the variable timer, turning
// its timeouts into registered step strobes and raising speed over time.
//
// state     | meaning
// ----------+-------------------------------------------------------------
// ST_IDLE   | after reset, waiting for the first GameStart
// ST_RUN    | timer enabled, timeouts become steps
// ST_PAUSED | timer held, speed and step count frozen
// ST_OVER   | game ended, speed kept for display, waits for GameStart
module speed_sequencer
    import speed_sequencer_pkg::*;
#(
    parameter int STEPS_PER_LEVEL = 16,
    parameter int START_SPEED     = 0,
    parameter int MAX_SPEED       = 3
) (
    input  logic               Clk,
    input  logic               Rst,
    input  logic               GameStart,
    input  logic               Pause,
    input  logic               GameOver,
    input  logic               TimeoutPulse,
    output logic               VarTimerEnable,
    output logic [SPEED_W-1:0] Speed,
    output logic               StepPulse,
    output logic               LevelUp,
    output logic               Running
);

    localparam logic [SPEED_W-1:0] MAX_VAL = clamp_speed(MAX_SPEED);

    state_t r_state;
    state_t w_next;
    logic   w_load;
    logic   w_accept;
    logic   r_enable;
    logic   r_running;
    logic   r_step;

    always_comb begin
        w_next   = r_state;
        w_load   = 1'b0;
        w_accept = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (GameStart) begin
                    w_next = ST_RUN;
                    w_load = 1'b1;
                end
            end
            ST_RUN: begin
                if (GameOver) begin
                    w_next = ST_OVER;
                end else if (GameStart) begin
                    w_next = ST_RUN;
                    w_load = 1'b1;
                end else if (Pause) begin
                    w_next = ST_PAUSED;
                end else if (TimeoutPulse) begin
                    w_accept = 1'b1;
                end
            end
            ST_PAUSED: begin
                if (GameOver) begin
                    w_next = ST_OVER;
                end else if (GameStart) begin
                    w_next = ST_RUN;
                    w_load = 1'b1;
                end else if (!Pause) begin
                    w_next = ST_RUN;
                end
            end
            ST_OVER: begin
                if (GameStart) begin
                    w_next = ST_RUN;
                    w_load = 1'b1;
                end
            end
            default: begin
                w_next = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge Clk or negedge Rst) begin
        if (!Rst) begin
            r_state   <= ST_IDLE;
            r_enable  <= 1'b0;
            r_running <= 1'b0;
            r_step    <= 1'b0;
        end else begin
            r_state   <= w_next;
            r_enable  <= (w_next == ST_RUN);
            r_running <= (w_next == ST_RUN);
            r_step    <= w_accept;
        end
    end

    speed_sequencer_level_counter #(
        .STEPS_PER_LEVEL (STEPS_PER_LEVEL),
        .START_SPEED     (START_SPEED)
    ) u_level_counter (
        .i_clk      (Clk),
        .i_rst_n    (Rst),
        .i_inc      (w_accept),
        .i_load     (w_load),
        .i_max      (MAX_VAL),
        .o_speed    (Speed),
        .o_level_up (LevelUp)
    );

    assign VarTimerEnable = r_enable;
    assign Running        = r_running;
    assign StepPulse      = r_step;

endmodule

// File: tb/tb_speed_sequencer.sv
// Self-checking bench: directed game scenarios followed by random play, all
// compared against a step-total reference model of the speed rules.
module tb_speed_sequencer;

    localparam int SPL   = 4;
    localparam int START = 0;
    localparam int MAXS  = 3;

    localparam int M_IDLE   = 0;
    localparam int M_RUN    = 1;
    localparam int M_PAUSED = 2;
    localparam int M_OVER   = 3;

    logic       Clk;
    logic       Rst;
    logic       GameStart;
    logic       Pause;
    logic       GameOver;
    logic       TimeoutPulse;
    logic       VarTimerEnable;
    logic [1:0] Speed;
    logic       StepPulse;
    logic       LevelUp;
    logic       Running;

    int checks   = 0;
    int failures = 0;

    int m_mode;
    int m_acc;
    int exp_step;
    int exp_lvl;
    int lvl_total;

    speed_sequencer #(
        .STEPS_PER_LEVEL (SPL),
        .START_SPEED     (START),
        .MAX_SPEED       (MAXS)
    ) dut (
        .Clk            (Clk),
        .Rst            (Rst),
        .GameStart      (GameStart),
        .Pause          (Pause),
        .GameOver       (GameOver),
        .TimeoutPulse   (TimeoutPulse),
        .VarTimerEnable (VarTimerEnable),
        .Speed          (Speed),
        .StepPulse      (StepPulse),
        .LevelUp        (LevelUp),
        .Running        (Running)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    function automatic int model_speed();
        int lv;
        lv = START + m_acc / SPL;
        return (lv > MAXS) ? MAXS : lv;
    endfunction

    task automatic chk(input string tag, input int obs, input int expv);
        checks++;
        assert (obs === expv) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
        end
    endtask

    task automatic model_reset();
        m_mode   = M_IDLE;
        m_acc    = 0;
        exp_step = 0;
        exp_lvl  = 0;
    endtask

    // Applies one cycle of game rules at the level of "accepted steps since start".
    task automatic model_cycle(input bit gs, input bit p, input bit go, input bit tp);
        exp_step = 0;
        exp_lvl  = 0;
        case (m_mode)
            M_IDLE: if (gs) begin m_mode = M_RUN; m_acc = 0; end
            M_RUN: begin
                if (go) m_mode = M_OVER;
                else if (gs) m_acc = 0;
                else if (p) m_mode = M_PAUSED;
                else if (tp) begin
                    m_acc++;
                    exp_step = 1;
                    if ((m_acc % SPL) == 0 && (START + m_acc / SPL) <= MAXS) exp_lvl = 1;
                end
            end
            M_PAUSED: begin
                if (go) m_mode = M_OVER;
                else if (gs) begin m_mode = M_RUN; m_acc = 0; end
                else if (!p) m_mode = M_RUN;
            end
            default: if (gs) begin m_mode = M_RUN; m_acc = 0; end
        endcase
    endtask

    task automatic check_all(input string ctx);
        int run_exp;
        run_exp = (m_mode == M_RUN) ? 1 : 0;
        chk({ctx, ".enable"}, int'(VarTimerEnable), run_exp);
        chk({ctx, ".running"}, int'(Running), run_exp);
        chk({ctx, ".speed"}, int'(Speed), model_speed());
        chk({ctx, ".step"}, int'(StepPulse), exp_step);
        chk({ctx, ".levelup"}, int'(LevelUp), exp_lvl);
        if (LevelUp === 1'b1) lvl_total++;
    endtask

    task automatic cycle(input string ctx, input bit gs, input bit p, input bit go, input bit tp);
        GameStart    = gs;
        Pause        = p;
        GameOver     = go;
        TimeoutPulse = tp;
        @(posedge Clk);
        #1;
        model_cycle(gs, p, go, tp);
        check_all(ctx);
    endtask

    initial begin
        bit r_p;
        Rst          = 1'b0;
        GameStart    = 1'b0;
        Pause        = 1'b0;
        GameOver     = 1'b0;
        TimeoutPulse = 1'b0;
        lvl_total    = 0;
        model_reset();
        repeat (2) @(posedge Clk);
        #1;
        check_all("reset");
        @(negedge Clk);
        Rst = 1'b1;

        cycle("idle_tp", 0, 0, 0, 1);
        cycle("start", 1, 0, 0, 0);

        for (int i = 0; i < SPL; i++) begin
            cycle("lvl1_tp", 0, 0, 0, 1);
            cycle("lvl1_gap", 0, 0, 0, 0);
        end
        chk("lvl1_speed", int'(Speed), 1);

        for (int i = 0; i < 3 * SPL; i++) cycle("lvl3_tp", 0, 0, 0, 1);
        chk("lvl3_speed", int'(Speed), 3);
        chk("lvl3_count", lvl_total, 3);
        for (int i = 0; i < SPL; i++) cycle("ceil_tp", 0, 0, 0, 1);
        chk("ceil_count", lvl_total, 3);

        cycle("pre_pause", 0, 0, 0, 1);
        for (int i = 0; i < 10; i++) cycle("paused", 0, 1, 0, 1);
        cycle("resume", 0, 0, 0, 0);
        for (int i = 0; i < SPL; i++) cycle("resume_tp", 0, 0, 0, 1);

        cycle("over_tp", 0, 0, 1, 1);
        chk("over_speed", int'(Speed), 3);
        cycle("over_ign", 0, 1, 0, 1);
        cycle("restart", 1, 0, 0, 0);
        for (int i = 0; i < SPL; i++) cycle("restart_tp", 0, 0, 0, 1);
        chk("restart_speed", int'(Speed), 1);

        cycle("start_tp", 1, 0, 0, 1);
        cycle("pause_tp", 0, 1, 0, 1);
        cycle("pstart", 1, 1, 0, 0);
        cycle("tp_after", 0, 0, 0, 1);

        r_p = 1'b0;
        for (int i = 0; i < 600; i++) begin
            bit gs;
            bit go;
            bit tp;
            gs = ($urandom_range(0, 99) < 3);
            go = ($urandom_range(0, 99) < 3);
            tp = ($urandom_range(0, 99) < 45);
            if ($urandom_range(0, 99) < 6) r_p = ~r_p;
            cycle("rand", gs, r_p, go, tp);
        end

        cycle("async_pre", 1, 0, 0, 0);
        for (int i = 0; i < 6; i++) cycle("async_tp", 0, 0, 0, 1);
        #2;
        Rst = 1'b0;
        #1;
        model_reset();
        check_all("async_rst");
        @(negedge Clk);
        Rst = 1'b1;
        for (int i = 0; i < 3; i++) cycle("post_rst", 0, 0, 0, 1);
        cycle("post_start", 1, 0, 0, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
